// File: rtl/mips_fetch_unit.sv
// Decoupled MIPS32 instruction fetch: PC, in-order imem request/response handshake,
// DEPTH-entry prefetch queue, and redirect / exception / interrupt vectoring with EPC capture.
module mips_fetch_unit #(
   parameter int unsigned ADDR_W    = 32,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
   parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
   parameter int unsigned DEPTH     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              exc,
   input  logic              irq,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic              out_valid,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pcp4,
   input  logic              out_ready,
   output logic              epc_we,
   output logic [ADDR_W-1:0] epc
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [ADDR_W-1:0] ResetPc  = ADDR_W'(RESET_VEC);
   localparam logic [ADDR_W-1:0] IrqPc    = ADDR_W'(IRQ_VEC);
   localparam logic [ADDR_W-1:0] ExcPc    = ADDR_W'(EXC_VEC);
   localparam logic [CntW:0]     DepthCnt = (CntW + 1)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   ifl_rd_q, ifl_rd_d, ifl_wr_q, ifl_wr_d;
   logic [CntW-1:0]   count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
   logic [31:0]       last_instr_q, last_instr_d;
   logic [ADDR_W-1:0] last_pc_q, last_pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic              epc_we_q, epc_we_d;
   logic              irq_mask_q, irq_mask_d;

   logic [31:0]       q_instr_q [DEPTH];
   logic [ADDR_W-1:0] q_pc_q    [DEPTH];
   logic [ADDR_W-1:0] ifl_pc_q  [DEPTH];

   logic              exc_take, redir_take, irq_take, flush;
   logic              grant, resp_keep, push, pop, credit;
   logic [ADDR_W-1:0] redir_aligned;

   always_comb begin
      out_valid = (count_q != '0);
      out_instr = out_valid ? q_instr_q[rd_ptr_q] : last_instr_q;
      out_pc    = out_valid ? q_pc_q[rd_ptr_q] : last_pc_q;
      out_pcp4  = out_pc + ADDR_W'(4);
      epc       = epc_q;
      epc_we    = epc_we_q;

      redir_aligned = redirect_pc & ~ADDR_W'(3);
      exc_take   = exc & out_valid & out_ready;
      redir_take = redirect_valid & ~exc_take;
      // User-mode head only; the head is re-executed after return, so it is not popped.
      irq_take   = irq & out_valid & ~out_pc[ADDR_W-1] & ~irq_mask_q & ~exc & ~redirect_valid;
      flush      = exc_take | redir_take | irq_take;

      credit    = ({1'b0, count_q} + {1'b0, inflight_q}) < DepthCnt;
      imem_req  = reset & credit & ~flush;
      imem_addr = fetch_pc_q;
      grant     = imem_req & imem_gnt;
      resp_keep = imem_rvalid & (drop_q == '0);
      push      = resp_keep & ~flush;
      pop       = out_valid & out_ready & ~flush;
   end

   always_comb begin
      fetch_pc_d   = grant ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
      inflight_d   = inflight_q + CntW'(grant) - CntW'(imem_rvalid);
      drop_d       = (imem_rvalid && drop_q != '0) ? drop_q - CntW'(1) : drop_q;
      ifl_wr_d     = ifl_wr_q + PtrW'(grant);
      ifl_rd_d     = ifl_rd_q + PtrW'(resp_keep);
      wr_ptr_d     = wr_ptr_q + PtrW'(push);
      rd_ptr_d     = rd_ptr_q + PtrW'(pop);
      count_d      = count_q + CntW'(push) - CntW'(pop);
      last_instr_d = pop ? out_instr : last_instr_q;
      last_pc_d    = pop ? out_pc : last_pc_q;
      epc_we_d     = exc_take | irq_take;
      epc_d        = (exc_take | irq_take) ? out_pc : epc_q;
      irq_mask_d   = irq_mask_q;
      if (irq_take) begin
         irq_mask_d = 1'b1;
      end else if (redir_take && !redir_aligned[ADDR_W-1]) begin
         irq_mask_d = 1'b0;
      end

      if (flush) begin
         // No grant is possible here, so every response still outstanding is stale.
         drop_d   = inflight_q - CntW'(imem_rvalid);
         ifl_wr_d = '0;
         ifl_rd_d = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         if (exc_take) begin
            fetch_pc_d = ExcPc;
         end else if (redir_take) begin
            fetch_pc_d = redir_aligned;
         end else begin
            fetch_pc_d = IrqPc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q   <= ResetPc;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         ifl_rd_q     <= '0;
         ifl_wr_q     <= '0;
         count_q      <= '0;
         inflight_q   <= '0;
         drop_q       <= '0;
         last_instr_q <= '0;
         last_pc_q    <= '0;
         epc_q        <= '0;
         epc_we_q     <= 1'b0;
         irq_mask_q   <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         ifl_rd_q     <= ifl_rd_d;
         ifl_wr_q     <= ifl_wr_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
         drop_q       <= drop_d;
         last_instr_q <= last_instr_d;
         last_pc_q    <= last_pc_d;
         epc_q        <= epc_d;
         epc_we_q     <= epc_we_d;
         irq_mask_q   <= irq_mask_d;
      end
   end

   // Storage arrays need no reset: pointers and counts qualify every read.
   always_ff @(posedge clk) begin
      if (grant) begin
         ifl_pc_q[ifl_wr_q] <= fetch_pc_q;
      end
      if (push) begin
         q_instr_q[wr_ptr_q] <= imem_rdata;
         q_pc_q[wr_ptr_q]    <= ifl_pc_q[ifl_rd_q];
      end
   end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: streaming, back-pressure, redirect drop, irq, exc,
// and PC wrap on a narrow instance, against a variable-latency memory model.
module tb_mips_fetch_unit;
   localparam logic [31:0] Key = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        exc = 1'b0;
   logic        irq = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic [31:0] out_instr, out_pc, out_pcp4;
   logic        out_ready = 1'b0;
   logic        epc_we;
   logic [31:0] epc;

   logic       w_req, w_valid, w_epc_we;
   logic [7:0] w_addr, w_pc, w_pcp4, w_epc;
   logic [31:0] w_instr;

   int n_checks = 0;
   int n_pass = 0;
   int lat = 1;
   int n_grants = 0;
   int cyc = 0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];

   always #5 clk = ~clk;

   mips_fetch_unit #(.ADDR_W(32), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exc(exc), .irq(irq), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
      .out_instr(out_instr), .out_pc(out_pc), .out_pcp4(out_pcp4), .out_ready(out_ready),
      .epc_we(epc_we), .epc(epc)
   );

   mips_fetch_unit #(.ADDR_W(8), .RESET_VEC(32'h0000_00FC), .DEPTH(4)) dut_wrap (
      .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(8'h00),
      .exc(1'b0), .irq(1'b0), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
      .imem_rvalid(1'b0), .imem_rdata(32'h0), .out_valid(w_valid),
      .out_instr(w_instr), .out_pc(w_pc), .out_pcp4(w_pcp4), .out_ready(1'b0),
      .epc_we(w_epc_we), .epc(w_epc)
   );

   // Memory: grants always, answers in order lat cycles after the grant.
   always @(posedge clk) begin
      #2;
      cyc++;
      imem_rvalid = 1'b0;
      if (!reset) begin
         pend_addr.delete();
         pend_due.delete();
      end else begin
         if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr[0] ^ Key;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         if (imem_req && imem_gnt) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
            n_grants++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy, input int l);
      reset = 1'b0;
      out_ready = rdy;
      lat = l;
      irq = 1'b0;
      exc = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      repeat (2) @(posedge clk);
      #4;
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      check("rst_epc_we", {31'h0, epc_we}, 32'h0);
      check("rst_epc", epc, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      n_grants = 0;
   endtask

   task automatic wait_head(input logic [31:0] pc, output logic found);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         next_cycle();
         if (out_valid && out_pc == pc) found = 1'b1;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic found;
      int   got;

      // Streaming with 1-cycle memory, plus the 8-bit wrap instance.
      do_reset(1'b1, 1);
      #3;
      check("s1_req0", {31'h0, imem_req}, 32'h1);
      check("s1_addr0", imem_addr, 32'h0);
      check("wrap_addr0", {24'h0, w_addr}, 32'h0000_00FC);
      next_cycle(); #3;
      check("s1_valid_c1", {31'h0, out_valid}, 32'h0);
      check("wrap_addr1", {24'h0, w_addr}, 32'h0000_0000);
      for (int k = 0; k < 6; k++) begin
         next_cycle(); #3;
         check("s1_valid", {31'h0, out_valid}, 32'h1);
         check("s1_pc", out_pc, 32'(4 * k));
         check("s1_pcp4", out_pcp4, 32'(4 * k + 4));
         check("s1_instr", out_instr, 32'(4 * k) ^ Key);
         if (k == 0) check("wrap_addr2", {24'h0, w_addr}, 32'h0000_0004);
         if (k == 2) check("wrap_full", {31'h0, w_req}, 32'h0);
      end

      // Back-pressure: 4 grants then stall; release delivers in order.
      do_reset(1'b0, 1);
      for (int c = 0; c < 9; c++) next_cycle();
      #3;
      check("s2_grants", 32'(n_grants), 32'd4);
      check("s2_req_full", {31'h0, imem_req}, 32'h0);
      next_cycle();
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 6; c++) begin
         #3;
         if (out_valid && out_ready) begin
            check("s2_pc", out_pc, 32'(4 * got));
            check("s2_instr", out_instr, 32'(4 * got) ^ Key);
            got++;
         end
         next_cycle();
      end
      check("s2_delivered", 32'(got), 32'd6);

      // Redirect (misaligned target) with two requests in flight on a 3-cycle memory.
      do_reset(1'b1, 3);
      next_cycle();
      next_cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      #3;
      check("s3_req_flush", {31'h0, imem_req}, 32'h0);
      next_cycle();
      redirect_valid = 1'b0;
      #3;
      check("s3_addr", imem_addr, 32'h0000_0100);
      check("s3_epc_we", {31'h0, epc_we}, 32'h0);
      for (int c = 3; c <= 8; c++) begin
         if (c > 3) begin next_cycle(); #3; end
         if (c <= 6) check("s3_bubble", {31'h0, out_valid}, 32'h0);
         else begin
            check("s3_valid", {31'h0, out_valid}, 32'h1);
            check("s3_pc", out_pc, 32'h0000_0100 + 32'(4 * (c - 7)));
            check("s3_instr", out_instr, (32'h0000_0100 + 32'(4 * (c - 7))) ^ Key);
         end
      end

      // Interrupt at user-mode head 0x20; held irq must not retrigger in kernel mode.
      do_reset(1'b1, 1);
      wait_head(32'h20, found);
      check("s4_head_seen", {31'h0, found}, 32'h1);
      irq = 1'b1;
      #3;
      check("s4_req_flush", {31'h0, imem_req}, 32'h0);
      next_cycle(); #3;
      check("s4_epc_we", {31'h0, epc_we}, 32'h1);
      check("s4_epc", epc, 32'h20);
      check("s4_valid_r1", {31'h0, out_valid}, 32'h0);
      check("s4_addr", imem_addr, 32'h8000_0004);
      next_cycle(); #3;
      check("s4_epc_we_r2", {31'h0, epc_we}, 32'h0);
      check("s4_valid_r2", {31'h0, out_valid}, 32'h0);
      next_cycle(); #3;
      check("s4_valid_r3", {31'h0, out_valid}, 32'h1);
      check("s4_pc_r3", out_pc, 32'h8000_0004);
      next_cycle(); #3;
      check("s4_pc_r4", out_pc, 32'h8000_0008);
      check("s4_epc_hold", epc, 32'h20);
      for (int c = 0; c < 3; c++) begin
         next_cycle(); #3;
         check("s4_no_retake", {31'h0, epc_we}, 32'h0);
      end
      irq = 1'b0;

      // Exception wins over a simultaneous redirect.
      do_reset(1'b1, 1);
      wait_head(32'h44, found);
      check("s5_head_seen", {31'h0, found}, 32'h1);
      exc = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      #3;
      check("s5_req_flush", {31'h0, imem_req}, 32'h0);
      next_cycle();
      exc = 1'b0;
      redirect_valid = 1'b0;
      #3;
      check("s5_epc_we", {31'h0, epc_we}, 32'h1);
      check("s5_epc", epc, 32'h44);
      check("s5_addr", imem_addr, 32'h8000_0008);
      next_cycle();
      next_cycle(); #3;
      check("s5_valid", {31'h0, out_valid}, 32'h1);
      check("s5_pc", out_pc, 32'h8000_0008);
      check("s5_instr", out_instr, 32'h8000_0008 ^ Key);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
